// File: rtl/vec_pipe_pkg.sv
// Shared types and helpers for the vector pipeline hazard logic.
// Entry fields are sized for the widest supported configuration.
// Narrower instances zero-extend into them.
package vec_pipe_pkg;

  // Widest register address and lane count any instance may use
  localparam int WA_MAX    = 8;
  localparam int LANES_MAX = 64;

  // Forwarding select value meaning "take the register file"
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                 valid;
    logic [WA_MAX-1:0]    dst;
    logic [WA_MAX-1:0]    srca;
    logic [WA_MAX-1:0]    srcb;
    logic                 use_b;
    logic [LANES_MAX-1:0] we;
    logic                 is_load;
  } hz_entry_t;

  // Bits needed to encode a select in 0..stages
  function automatic int selw(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/vec_fwd_lane.sv
// One lane, one operand: pick the youngest older stage that writes this lane.
// Latency: combinational.
// Backpressure: none; the caller freezes the inputs while the pipe is held.
module vec_fwd_lane
  import vec_pipe_pkg::*;
#(
  parameter  int STAGES = 3,
  localparam int SELW   = selw(STAGES)
) (
  input  logic              en,
  input  logic [STAGES-2:0] vld,
  input  logic [STAGES-2:0] match,
  input  logic [STAGES-2:0] we,
  output logic [SELW-1:0]   sel
);

  // Scan oldest to youngest so the youngest hit (smallest stage) wins
  always_comb begin
    sel = SELW'(SEL_RF);
    if (en) begin
      for (int i = STAGES - 2; i >= 0; i--) begin
        if (vld[i] && match[i] && we[i]) begin
          sel = SELW'(i + 2);
        end
      end
    end
  end

endmodule

// File: rtl/vec_hazard_ctrl.sv
// Hazard and forwarding control for the vector SIMD pipeline.
// Latency: stall/ready/selects combinational from state; inflight registered.
// Backpressure: iss_ready drops on exe_busy, load-use stall or flush.
module vec_hazard_ctrl
  import vec_pipe_pkg::*;
#(
  parameter  int WIDTH_VECTOR = 16,
  parameter  int WA_RF        = 4,
  parameter  int STAGES       = 3,
  parameter  int LOAD_STAGE   = 3,
  parameter  int FLUSH_DEPTH  = 1,
  localparam int SELW         = selw(STAGES),
  localparam int CNTW         = $clog2(STAGES + 1)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         iss_valid,
  output logic                         iss_ready,
  input  logic [WA_RF-1:0]             iss_dst,
  input  logic [WA_RF-1:0]             iss_srca,
  input  logic [WA_RF-1:0]             iss_srcb,
  input  logic                         iss_use_b,
  input  logic [WIDTH_VECTOR-1:0]      iss_we,
  input  logic                         iss_is_load,
  input  logic                         flush,
  input  logic                         exe_busy,
  output logic [WIDTH_VECTOR*SELW-1:0] fwd_sel_a,
  output logic [WIDTH_VECTOR*SELW-1:0] fwd_sel_b,
  output logic                         stall,
  output logic [CNTW-1:0]              inflight
);

  localparam logic [LANES_MAX-1:0] LANE_MASK = {LANES_MAX{1'b1}} >> (LANES_MAX - WIDTH_VECTOR);

  hz_entry_t       stg_q [1:STAGES];
  hz_entry_t       stg_d [1:STAGES];
  hz_entry_t       kept  [1:STAGES];
  hz_entry_t       iss_ent;
  logic            hazard;
  logic            iss_fire;
  logic [CNTW-1:0] cnt_d;

  // Pack the issuing instruction into an entry
  always_comb begin
    iss_ent         = '0;
    iss_ent.valid   = 1'b1;
    iss_ent.dst     = WA_MAX'(iss_dst);
    iss_ent.srca    = WA_MAX'(iss_srca);
    iss_ent.srcb    = WA_MAX'(iss_srcb);
    iss_ent.use_b   = iss_use_b;
    iss_ent.we      = LANES_MAX'(iss_we);
    iss_ent.is_load = iss_is_load;
  end

  // Load-use: per lane and source, the youngest writer must not be a load too young to forward
  always_comb begin
    logic [WA_MAX-1:0] src;
    logic              hit;
    logic              hit_ld;
    int                hit_j;
    hazard = 1'b0;
    src    = '0;
    hit    = 1'b0;
    hit_ld = 1'b0;
    hit_j  = 0;
    for (int l = 0; l < WIDTH_VECTOR; l++) begin
      for (int s = 0; s < 2; s++) begin
        src    = (s == 0) ? iss_ent.srca : iss_ent.srcb;
        hit    = 1'b0;
        hit_ld = 1'b0;
        hit_j  = 0;
        for (int j = STAGES; j >= 1; j--) begin
          if (stg_q[j].valid && (stg_q[j].dst == src) && stg_q[j].we[l]) begin
            hit    = 1'b1;
            hit_ld = stg_q[j].is_load;
            hit_j  = j;
          end
        end
        if ((s == 0 || iss_use_b) && hit && hit_ld && (hit_j + 1 < LOAD_STAGE)) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall     = iss_valid && hazard;
  assign iss_ready = !exe_busy && !stall && !flush;
  assign iss_fire  = iss_valid && iss_ready;

  // Kill the youngest stages on flush, then shift unless the ALU is holding
  always_comb begin
    for (int k = 1; k <= STAGES; k++) begin
      kept[k] = stg_q[k];
      if (flush && (k <= FLUSH_DEPTH)) begin
        kept[k].valid = 1'b0;
      end
    end
    stg_d = kept;
    if (!exe_busy) begin
      stg_d[1] = iss_fire ? iss_ent : '0;
      for (int k = 2; k <= STAGES; k++) begin
        stg_d[k] = kept[k-1];
      end
    end
  end

  // Occupancy of the next state, so the register tracks the entries it sits beside
  always_comb begin
    cnt_d = '0;
    for (int k = 1; k <= STAGES; k++) begin
      cnt_d = cnt_d + CNTW'(stg_d[k].valid);
    end
  end

  // Pipeline entries and occupancy counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_q    <= '{default: '0};
      inflight <= '0;
    end else begin
      stg_q    <= stg_d;
      inflight <= cnt_d;
    end
  end

  // Forwarding: stages 2..STAGES against the consumer sitting in execute
  logic [STAGES-2:0] old_vld;
  logic [STAGES-2:0] hit_a;
  logic [STAGES-2:0] hit_b;
  logic              en_a;
  logic              en_b;

  assign en_a = stg_q[1].valid;
  assign en_b = stg_q[1].valid && stg_q[1].use_b;

  for (genvar k = 2; k <= STAGES; k++) begin : g_old
    assign old_vld[k-2] = stg_q[k].valid;
    assign hit_a[k-2]   = (stg_q[k].dst == stg_q[1].srca);
    assign hit_b[k-2]   = (stg_q[k].dst == stg_q[1].srcb);
  end

  for (genvar l = 0; l < WIDTH_VECTOR; l++) begin : g_lane
    logic [STAGES-2:0] we_l;
    for (genvar k = 2; k <= STAGES; k++) begin : g_we
      assign we_l[k-2] = stg_q[k].we[l];
    end
    vec_fwd_lane #(.STAGES(STAGES)) u_fwd_a (
      .en    (en_a),
      .vld   (old_vld),
      .match (hit_a),
      .we    (we_l),
      .sel   (fwd_sel_a[l*SELW +: SELW])
    );
    vec_fwd_lane #(.STAGES(STAGES)) u_fwd_b (
      .en    (en_b),
      .vld   (old_vld),
      .match (hit_b),
      .we    (we_l),
      .sel   (fwd_sel_b[l*SELW +: SELW])
    );
  end

  logic load_fwd_bad;
  logic we_pad_bad;

  // A load selected before its data stage, or a write enable above the lane count
  always_comb begin
    load_fwd_bad = 1'b0;
    we_pad_bad   = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      we_pad_bad = we_pad_bad | (|(stg_q[k].we & ~LANE_MASK));
      if (stg_q[k].is_load && (k < LOAD_STAGE)) begin
        for (int l = 0; l < WIDTH_VECTOR; l++) begin
          if ((fwd_sel_a[l*SELW +: SELW] == SELW'(k)) ||
              (fwd_sel_b[l*SELW +: SELW] == SELW'(k))) begin
            load_fwd_bad = 1'b1;
          end
        end
      end
    end
  end

  // Load-use stall must make early load forwarding impossible
  always @(posedge clk) begin
    if (rstn) begin
      assert (!load_fwd_bad);
      assert (!we_pad_bad);
    end
  end

endmodule

// File: tb/tb_vec_hazard_ctrl.sv
// Bench for vec_hazard_ctrl: directed hazard scenarios then random traffic.
// Reference keeps in-flight instructions as a queue of records tagged by stage.
// Outputs are checked mid-cycle against the reference and fixed constants.
module tb_vec_hazard_ctrl;

  localparam int WV = 4;
  localparam int WA = 4;
  localparam int ST = 3;
  localparam int LS = 3;
  localparam int FD = 1;

  logic       clk;
  logic       rstn;
  logic       iss_valid;
  logic       iss_ready;
  logic [3:0] iss_dst;
  logic [3:0] iss_srca;
  logic [3:0] iss_srcb;
  logic       iss_use_b;
  logic [3:0] iss_we;
  logic       iss_is_load;
  logic       flush;
  logic       exe_busy;
  logic [7:0] fwd_sel_a;
  logic [7:0] fwd_sel_b;
  logic       stall;
  logic [1:0] inflight;

  int n_vec = 0;
  int n_err = 0;

  vec_hazard_ctrl #(
    .WIDTH_VECTOR(WV), .WA_RF(WA), .STAGES(ST), .LOAD_STAGE(LS), .FLUSH_DEPTH(FD)
  ) dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_dst(iss_dst), .iss_srca(iss_srca), .iss_srcb(iss_srcb),
    .iss_use_b(iss_use_b), .iss_we(iss_we), .iss_is_load(iss_is_load),
    .flush(flush), .exe_busy(exe_busy),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall(stall), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         stg;
    logic [3:0] dst;
    logic [3:0] srca;
    logic [3:0] srcb;
    logic [3:0] we;
    logic       ld;
    logic       use_b;
  } rec_t;

  rec_t q[$];

  // Youngest in-flight writer of each lane/source; stall if it is a load whose data is not yet reachable
  function automatic logic m_stall();
    if (!iss_valid) return 1'b0;
    for (int l = 0; l < WV; l++) begin
      for (int s = 0; s < 2; s++) begin
        logic [3:0] src;
        int         best;
        logic       bld;
        src  = (s == 0) ? iss_srca : iss_srcb;
        best = 99;
        bld  = 1'b0;
        if (s == 1 && !iss_use_b) continue;
        foreach (q[i]) begin
          if (q[i].dst == src && q[i].we[l] && q[i].stg < best) begin
            best = q[i].stg;
            bld  = q[i].ld;
          end
        end
        if (best != 99 && bld && (best + 1 < LS)) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic m_ready();
    return !exe_busy && !flush && !m_stall();
  endfunction

  // Per lane: nearest older stage (2..ST) writing the consumer's source in that lane
  function automatic logic [7:0] m_sel(input bit is_b);
    logic [7:0] r;
    logic [3:0] src;
    int         c;
    int         best;
    r = '0;
    c = -1;
    foreach (q[i]) if (q[i].stg == 1) c = i;
    if (c < 0) return r;
    if (is_b && !q[c].use_b) return r;
    src = is_b ? q[c].srcb : q[c].srca;
    for (int l = 0; l < WV; l++) begin
      best = 0;
      foreach (q[i]) begin
        if (q[i].stg >= 2 && q[i].dst == src && q[i].we[l] && (best == 0 || q[i].stg < best))
          best = q[i].stg;
      end
      r[l*2 +: 2] = 2'(best);
    end
    return r;
  endfunction

  task automatic m_clock();
    logic acc;
    rec_t nq[$];
    rec_t r;
    acc = iss_valid && m_ready();
    if (flush) begin
      foreach (q[i]) if (q[i].stg > FD) nq.push_back(q[i]);
      q = nq;
    end
    if (!exe_busy) begin
      nq.delete();
      foreach (q[i]) if (q[i].stg + 1 <= ST) begin
        r = q[i];
        r.stg = r.stg + 1;
        nq.push_back(r);
      end
      q = nq;
      if (acc) begin
        r.stg = 1; r.dst = iss_dst; r.srca = iss_srca; r.srcb = iss_srcb;
        r.we = iss_we; r.ld = iss_is_load; r.use_b = iss_use_b;
        q.push_back(r);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, ":ready"},    32'(iss_ready), 32'(m_ready()));
    chk({ph, ":stall"},    32'(stall),     32'(m_stall()));
    chk({ph, ":sel_a"},    32'(fwd_sel_a), 32'(m_sel(1'b0)));
    chk({ph, ":sel_b"},    32'(fwd_sel_b), 32'(m_sel(1'b1)));
    chk({ph, ":inflight"}, 32'(inflight),  32'(q.size()));
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [3:0] sa, input logic [3:0] sb,
                       input logic ub, input logic [3:0] we, input logic ld, input logic fl, input logic bz);
    iss_valid = v; iss_dst = d; iss_srca = sa; iss_srcb = sb; iss_use_b = ub;
    iss_we = we; iss_is_load = ld; flush = fl; exe_busy = bz;
  endtask

  task automatic settle(input string ph);
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      settle("idle");
      tick();
    end
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_all("reset");
    chk("reset_ready", 32'(iss_ready), 32'd1);
    @(posedge clk);
    #1 rstn = 1'b1;

    // back-to-back ALU forwarding from stage 2
    drive(1, 4'd2, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("b2b0"); tick();
    drive(1, 4'd7, 4'd2, 4'd0, 0, 4'hF, 0, 0, 0); settle("b2b1"); tick();
    drive(1, 4'd8, 4'd3, 4'd0, 0, 4'hF, 0, 0, 0); settle("b2b2");
    chk("b2b_sel_a", 32'(fwd_sel_a), 32'h0000_00AA);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("b2b3");
    chk("b2b_next_sel_a", 32'(fwd_sel_a), 32'h0);
    tick();
    idle(3);

    // load-use: one stall cycle, then forward from stage 3
    drive(1, 4'd5, 4'd0, 4'd0, 0, 4'hF, 1, 0, 0); settle("ld0"); tick();
    drive(1, 4'd9, 4'd5, 4'd0, 0, 4'hF, 0, 0, 0); settle("ld1");
    chk("ld_stall", 32'(stall), 32'd1);
    chk("ld_ready_lo", 32'(iss_ready), 32'd0);
    tick();
    settle("ld2");
    chk("ld_stall_gone", 32'(stall), 32'd0);
    chk("ld_ready_hi", 32'(iss_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("ld3");
    chk("ld_sel_a", 32'(fwd_sel_a), 32'h0000_00FF);
    tick();
    idle(3);

    // partial masks merge per lane
    drive(1, 4'd1, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("pm0"); tick();
    drive(1, 4'd1, 4'd0, 4'd0, 0, 4'h3, 0, 0, 0); settle("pm1"); tick();
    drive(1, 4'd6, 4'd1, 4'd1, 1, 4'hF, 0, 0, 0); settle("pm2"); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("pm3");
    chk("pm_sel_a", 32'(fwd_sel_a), 32'h0000_00FA);
    chk("pm_sel_b", 32'(fwd_sel_b), 32'h0000_00FA);
    tick();
    idle(3);

    // flush kills stage 1
    drive(1, 4'd3, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("fl0"); tick();
    drive(1, 4'd4, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("fl1"); tick();
    drive(1, 4'd9, 4'd4, 4'd0, 0, 4'hF, 0, 1, 0); settle("fl2");
    chk("fl_ready", 32'(iss_ready), 32'd0);
    chk("fl_inflight_pre", 32'(inflight), 32'd2);
    tick();
    drive(1, 4'd9, 4'd4, 4'd0, 0, 4'hF, 0, 0, 0); settle("fl3");
    chk("fl_inflight_post", 32'(inflight), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("fl4");
    chk("fl_no_fwd", 32'(fwd_sel_a), 32'h0);
    tick();
    idle(3);

    // exe_busy freezes for 3 cycles
    drive(1, 4'd10, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("bz0"); tick();
    drive(1, 4'd11, 4'd10, 4'd0, 0, 4'hF, 0, 0, 0); settle("bz1"); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'd12, 4'd11, 4'd0, 0, 4'hF, 0, 0, 1); settle("bz_hold");
      chk("bz_ready", 32'(iss_ready), 32'd0);
      chk("bz_sel_a", 32'(fwd_sel_a), 32'h0000_00AA);
      chk("bz_inflight", 32'(inflight), 32'd2);
      tick();
    end
    drive(1, 4'd12, 4'd11, 4'd0, 0, 4'hF, 0, 0, 0); settle("bz2");
    chk("bz_release_ready", 32'(iss_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("bz3");
    chk("bz_after_sel_a", 32'(fwd_sel_a), 32'h0000_00AA);
    chk("bz_after_inflight", 32'(inflight), 32'd3);

    // asynchronous reset with three entries live
    #1 rstn = 1'b0;
    q.delete();
    #1;
    check_all("arst");
    chk("arst_inflight", 32'(inflight), 32'd0);
    chk("arst_sel_a", 32'(fwd_sel_a), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    drive(1, 4'd13, 4'd0, 4'd0, 0, 4'hF, 0, 0, 0); settle("rel0");
    chk("rel_ready", 32'(iss_ready), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); settle("rel1");
    chk("rel_inflight", 32'(inflight), 32'd1);
    tick();

    // random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0,
            4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)), 4'($urandom_range(1, 4)),
            $urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3);
      settle("rnd");
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
